aemb_uwb_arbiter: RTL and testbench

//  Shares the single unified-memory wishbone port of the aeMB unified core between the

---
 rtl/aemb_uwb_arbiter_if.sv | 56 +++++
 rtl/aemb_uwb_arbiter.sv | 120 ++++++++++++
 tb/tb_aemb_uwb_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aemb_uwb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : aemb_uwb_arbiter_if
//  Brief    : Wishbone signal bundle for the aeMB unified-memory arbiter.
//             Holds the instruction master, data master and shared slave ports.
//  Revision : 1.0 - initial release
// ============================================================================
interface aemb_uwb_arbiter_if #(
  parameter int ASIZ = 16
);
  // instruction master
  logic [ASIZ-1:0] iwb_adr_i;
  logic            iwb_stb_i;
  logic [31:0]     iwb_dat_o;
  logic            iwb_ack_o;
  // data master
  logic [ASIZ-1:0] dwb_adr_i;
  logic [31:0]     dwb_dat_i;
  logic [3:0]      dwb_sel_i;
  logic            dwb_we_i;
  logic            dwb_stb_i;
  logic [31:0]     dwb_dat_o;
  logic            dwb_ack_o;
  // shared slave bus
  logic [ASIZ-1:0] wb_adr_o;
  logic [31:0]     wb_dat_o;
  logic [3:0]      wb_sel_o;
  logic            wb_stb_o;
  logic            wb_wre_o;
  logic [31:0]     wb_dat_i;
  logic            wb_ack_i;
  // status
  logic            arb_err_o;
  logic [1:0]      arb_gnt_o;

  // Arbiter view: receives both master requests and the slave response.
  modport slave (
    input  iwb_adr_i, iwb_stb_i,
    input  dwb_adr_i, dwb_dat_i, dwb_sel_i, dwb_we_i, dwb_stb_i,
    input  wb_dat_i, wb_ack_i,
    output iwb_dat_o, iwb_ack_o, dwb_dat_o, dwb_ack_o,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_stb_o, wb_wre_o,
    output arb_err_o, arb_gnt_o
  );

  // Environment view: drives master requests and slave responses.
  modport master (
    output iwb_adr_i, iwb_stb_i,
    output dwb_adr_i, dwb_dat_i, dwb_sel_i, dwb_we_i, dwb_stb_i,
    output wb_dat_i, wb_ack_i,
    input  iwb_dat_o, iwb_ack_o, dwb_dat_o, dwb_ack_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_stb_o, wb_wre_o,
    input  arb_err_o, arb_gnt_o
  );
endinterface
`default_nettype wire

// File: rtl/aemb_uwb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : aemb_uwb_arbiter
//  Brief    : Round-robin arbiter sharing one wishbone port between the aeMB
//             instruction and data masters, with a hung-slave watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module aemb_uwb_arbiter #(
  parameter int ASIZ = 16,
  parameter int TOUT = 255
) (
  input  wire logic         sys_clk_i,
  input  wire logic         sys_rst_i,
  aemb_uwb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GI   = 2'b01,
    GD   = 2'b10
  } state_t;

  // Count value reached in the TOUT-th unacknowledged grant cycle.
  localparam logic [7:0] WD_LIM = 8'((TOUT == 0) ? 0 : TOUT - 1);

  state_t          state, state_nxt;
  logic            last, last_nxt;      // last granted master: 0 iwb, 1 dwb
  logic [7:0]      wd_cnt, wd_nxt;
  logic            gnt_i, gnt_d, stb_g, wd_expire, term;
  logic [ASIZ-1:0] adr_mux;

  // Grant decode, watchdog expiry and transaction termination.
  always_comb begin
    gnt_i     = (state == GI);
    gnt_d     = (state == GD);
    stb_g     = (gnt_i & bus.iwb_stb_i) | (gnt_d & bus.dwb_stb_i);
    wd_expire = (TOUT != 0) && stb_g && (wd_cnt == WD_LIM) && !bus.wb_ack_i;
    term      = stb_g & (bus.wb_ack_i | wd_expire);
  end

  // Next-state, round-robin bookkeeping and watchdog count.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (bus.iwb_stb_i && bus.dwb_stb_i) state_nxt = last ? GI : GD;
        else if (bus.iwb_stb_i)             state_nxt = GI;
        else if (bus.dwb_stb_i)             state_nxt = GD;
      end
      GI: begin
        if (term) begin
          last_nxt  = 1'b0;
          state_nxt = bus.dwb_stb_i ? GD : IDLE;
        end else if (!bus.iwb_stb_i) begin
          state_nxt = IDLE;   // withdrawal leaves the round-robin pointer alone
        end
      end
      GD: begin
        if (term) begin
          last_nxt  = 1'b1;
          state_nxt = bus.iwb_stb_i ? GI : IDLE;
        end else if (!bus.dwb_stb_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Clear on any grant change or termination, otherwise saturate upwards.
    if ((state_nxt != state) || term)
      wd_nxt = 8'd0;
    else if ((gnt_i || gnt_d) && !bus.wb_ack_i && (wd_cnt != 8'hFF))
      wd_nxt = wd_cnt + 8'd1;
    else
      wd_nxt = wd_cnt;
  end

  // State, round-robin pointer and watchdog registers.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state  <= IDLE;
      last   <= 1'b0;
      wd_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      wd_cnt <= wd_nxt;
    end
  end

  // Shared bus and master return paths, steered purely by the grant state.
  always_comb begin
    adr_mux      = '0;
    bus.wb_dat_o = 32'd0;
    bus.wb_sel_o = 4'h0;
    bus.wb_wre_o = 1'b0;
    bus.wb_stb_o = 1'b0;
    if (gnt_i) begin
      adr_mux      = bus.iwb_adr_i;
      bus.wb_sel_o = 4'hF;
      bus.wb_stb_o = bus.iwb_stb_i;
    end else if (gnt_d) begin
      adr_mux      = bus.dwb_adr_i;
      bus.wb_dat_o = bus.dwb_dat_i;
      bus.wb_sel_o = bus.dwb_sel_i;
      bus.wb_wre_o = bus.dwb_we_i;
      bus.wb_stb_o = bus.dwb_stb_i;
    end
    bus.wb_adr_o  = adr_mux;
    bus.iwb_ack_o = gnt_i & bus.iwb_stb_i & (bus.wb_ack_i | wd_expire);
    bus.dwb_ack_o = gnt_d & bus.dwb_stb_i & (bus.wb_ack_i | wd_expire);
    bus.iwb_dat_o = (gnt_i && !wd_expire) ? bus.wb_dat_i : 32'd0;
    bus.dwb_dat_o = (gnt_d && !wd_expire) ? bus.wb_dat_i : 32'd0;
    bus.arb_err_o = wd_expire;
    bus.arb_gnt_o = state;
  end

endmodule
`default_nettype wire

// File: tb/tb_aemb_uwb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aemb_uwb_arbiter
//  Brief    : Self-checking bench for aemb_uwb_arbiter with a result queue.
//             Instance "dut" uses TOUT=4, instance "dz" uses TOUT=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aemb_uwb_arbiter;

  typedef struct {
    logic        m;   // 0 iwb, 1 dwb
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  exp_t q[$];

  aemb_uwb_arbiter_if #(.ASIZ(16)) bi ();
  aemb_uwb_arbiter_if #(.ASIZ(16)) bz ();

  aemb_uwb_arbiter #(.ASIZ(16), .TOUT(4)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (bi.slave)
  );

  aemb_uwb_arbiter #(.ASIZ(16), .TOUT(0)) dz (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (bz.slave)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bi.iwb_stb_i = 1'b0; bi.dwb_stb_i = 1'b0; bi.wb_ack_i = 1'b0;
    bz.iwb_stb_i = 1'b0; bz.dwb_stb_i = 1'b0; bz.wb_ack_i = 1'b0;
    bi.dwb_we_i  = 1'b0; bi.dwb_sel_i = 4'h0; bi.dwb_dat_i = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bi.iwb_stb_i = 1'b1; bi.dwb_stb_i = 1'b1; bi.wb_ack_i = 1'b1;
    bi.iwb_adr_i = 16'h1234; bi.dwb_adr_i = 16'h4321; bi.dwb_we_i = 1'b1;
    bi.dwb_sel_i = 4'h3; bi.dwb_dat_i = 32'h5555AAAA; bi.wb_dat_i = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        @(negedge clk);
        rst = 1'b0; bi.wb_ack_i = 1'b0;
      end else begin
        @(negedge clk);
      end
      #1;
      nvec++;
      if (bi.arb_gnt_o !== 2'b00 || bi.wb_stb_o !== 1'b0 || bi.wb_adr_o !== 16'h0 ||
          bi.wb_sel_o !== 4'h0 || bi.wb_wre_o !== 1'b0 || bi.wb_dat_o !== 32'h0 ||
          bi.iwb_ack_o !== 1'b0 || bi.dwb_ack_o !== 1'b0 || bi.arb_err_o !== 1'b0 ||
          bi.iwb_dat_o !== 32'h0 || bi.dwb_dat_o !== 32'h0) begin
        nerr++;
        $display("FAIL reset_idle[%0d] gnt=%b stb=%b adr=%h acks=%b%b err=%b, required all zero",
                 i, bi.arb_gnt_o, bi.wb_stb_o, bi.wb_adr_o, bi.dwb_ack_o, bi.iwb_ack_o, bi.arb_err_o);
      end
    end
    @(negedge clk); #1;
    nvec++;
    if (bi.arb_gnt_o !== 2'b10 || bi.wb_stb_o !== 1'b1 || bi.wb_adr_o !== 16'h4321 || bi.wb_wre_o !== 1'b1) begin
      nerr++;
      $display("FAIL reset_tie_dwb gnt=%b stb=%b adr=%h wre=%b, required 10 1 4321 1",
               bi.arb_gnt_o, bi.wb_stb_o, bi.wb_adr_o, bi.wb_wre_o);
    end
    @(negedge clk);
    bi.iwb_stb_i = 1'b0; bi.dwb_stb_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_iwb_read();
    exp_t e;
    do_reset();
    bi.iwb_adr_i = 16'h0100; bi.iwb_stb_i = 1'b1;
    #1;
    nvec++;
    if (bi.wb_stb_o !== 1'b0) begin
      nerr++; $display("FAIL iwb_latency_n wb_stb_o=%b, required 0", bi.wb_stb_o);
    end
    @(negedge clk); #1;
    nvec++;
    if (bi.wb_stb_o !== 1'b1 || bi.wb_adr_o !== 16'h0100 || bi.wb_sel_o !== 4'hF ||
        bi.wb_wre_o !== 1'b0 || bi.arb_gnt_o !== 2'b01 || bi.iwb_ack_o !== 1'b0) begin
      nerr++;
      $display("FAIL iwb_grant stb=%b adr=%h sel=%h wre=%b gnt=%b ack=%b, required 1 0100 f 0 01 0",
               bi.wb_stb_o, bi.wb_adr_o, bi.wb_sel_o, bi.wb_wre_o, bi.arb_gnt_o, bi.iwb_ack_o);
    end
    @(negedge clk);
    bi.wb_ack_i = 1'b1; bi.wb_dat_i = 32'hB0000000;
    q.push_back('{1'b0, 32'hB0000000});
    #1;
    e = q.pop_front();
    nvec++;
    if (bi.iwb_ack_o !== 1'b1 || bi.iwb_dat_o !== e.d || bi.dwb_ack_o !== 1'b0) begin
      nerr++;
      $display("FAIL iwb_ack ack=%b dat=%h dack=%b, required 1 %h 0",
               bi.iwb_ack_o, bi.iwb_dat_o, bi.dwb_ack_o, e.d);
    end
    @(negedge clk);
    bi.wb_ack_i = 1'b0; bi.iwb_stb_i = 1'b0;
    #1;
    nvec++;
    if (bi.arb_gnt_o !== 2'b00) begin
      nerr++; $display("FAIL iwb_done gnt=%b, required 00", bi.arb_gnt_o);
    end
  endtask

  task automatic test_tie();
    logic [1:0] eg [6];
    exp_t e;
    eg = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
    do_reset();
    bi.iwb_adr_i = 16'h0040; bi.dwb_adr_i = 16'h0080; bi.dwb_we_i = 1'b0;
    bi.iwb_stb_i = 1'b1; bi.dwb_stb_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      bi.wb_ack_i = (i == 2 || i == 4);
      bi.wb_dat_i = (i == 2) ? 32'hD0D00002 : 32'h11110004;
      if (i == 2) q.push_back('{1'b1, 32'hD0D00002});
      if (i == 4) q.push_back('{1'b0, 32'h11110004});
      if (i == 3) bi.dwb_stb_i = 1'b0;
      if (i == 5) bi.iwb_stb_i = 1'b0;
      #1;
      nvec++;
      if (bi.arb_gnt_o !== eg[i]) begin
        nerr++; $display("FAIL tie_gnt[%0d] gnt=%b, required %b", i, bi.arb_gnt_o, eg[i]);
      end
      nvec++;
      if (q.size() > 0) begin
        e = q.pop_front();
        if ({bi.dwb_ack_o, bi.iwb_ack_o} !== (e.m ? 2'b10 : 2'b01) ||
            (e.m ? bi.dwb_dat_o : bi.iwb_dat_o) !== e.d) begin
          nerr++;
          $display("FAIL tie_ack[%0d] acks=%b%b idat=%h ddat=%h, required master %0d dat %h",
                   i, bi.dwb_ack_o, bi.iwb_ack_o, bi.iwb_dat_o, bi.dwb_dat_o, e.m, e.d);
        end
      end else if (bi.iwb_ack_o !== 1'b0 || bi.dwb_ack_o !== 1'b0) begin
        nerr++;
        $display("FAIL tie_noack[%0d] acks=%b%b, required 00", i, bi.dwb_ack_o, bi.iwb_ack_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   k, wcnt, nack_i, nack_d;
    logic exp_m;
    do_reset();
    bi.iwb_adr_i = 16'h1000; bi.dwb_adr_i = 16'h2000; bi.dwb_we_i = 1'b0;
    bi.iwb_stb_i = 1'b1; bi.dwb_stb_i = 1'b1;
    k = 0; wcnt = 0; nack_i = 0; nack_d = 0; exp_m = 1'b1;
    for (int cyc = 0; cyc < 60 && k < 8; cyc++) begin
      @(negedge clk);
      bi.wb_ack_i = 1'b0; bi.wb_dat_i = 32'd0;
      #1;
      nvec++;
      if (bi.arb_gnt_o !== (exp_m ? 2'b10 : 2'b01)) begin
        nerr++;
        $display("FAIL b2b_gnt[%0d] gnt=%b, required %b", cyc, bi.arb_gnt_o, exp_m ? 2'b10 : 2'b01);
      end
      if (bi.wb_stb_o === 1'b1) begin
        if (wcnt >= 1) begin
          bi.wb_ack_i = 1'b1;
          bi.wb_dat_i = {16'hC0DE, bi.wb_adr_o};
          q.push_back('{exp_m, {16'hC0DE, exp_m ? bi.dwb_adr_i : bi.iwb_adr_i}});
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      #1;
      nvec++;
      if (q.size() > 0) begin
        e = q.pop_front();
        if ({bi.dwb_ack_o, bi.iwb_ack_o} !== (e.m ? 2'b10 : 2'b01) ||
            (e.m ? bi.dwb_dat_o : bi.iwb_dat_o) !== e.d) begin
          nerr++;
          $display("FAIL b2b_ack[%0d] acks=%b%b idat=%h ddat=%h, required master %0d dat %h",
                   k, bi.dwb_ack_o, bi.iwb_ack_o, bi.iwb_dat_o, bi.dwb_dat_o, e.m, e.d);
        end
        if (bi.dwb_ack_o === 1'b1) begin nack_d++; bi.dwb_adr_i = bi.dwb_adr_i + 16'd4; end
        if (bi.iwb_ack_o === 1'b1) begin nack_i++; bi.iwb_adr_i = bi.iwb_adr_i + 16'd4; end
        exp_m = ~exp_m;
        k++;
      end else if (bi.iwb_ack_o !== 1'b0 || bi.dwb_ack_o !== 1'b0) begin
        nerr++;
        $display("FAIL b2b_noack acks=%b%b, required 00", bi.dwb_ack_o, bi.iwb_ack_o);
      end
    end
    nvec++;
    if (k != 8 || nack_i != 4 || nack_d != 4) begin
      nerr++;
      $display("FAIL b2b_count trans=%0d iacks=%0d dacks=%0d, required 8 4 4", k, nack_i, nack_d);
    end
    @(negedge clk);
    bi.wb_ack_i = 1'b0; bi.iwb_stb_i = 1'b0; bi.dwb_stb_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dwb_write();
    logic [1:0] eg [7];
    exp_t e;
    eg = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
    do_reset();
    bi.dwb_adr_i = 16'h8888; bi.dwb_dat_i = 32'h7A55ED00; bi.dwb_sel_i = 4'hF;
    bi.dwb_we_i = 1'b1; bi.dwb_stb_i = 1'b1;
    bi.iwb_adr_i = 16'h0200; bi.iwb_stb_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      bi.wb_ack_i = (i == 3 || i == 5);
      bi.wb_dat_i = (i == 3) ? 32'h00000001 : 32'hCAFE0200;
      if (i == 3) q.push_back('{1'b1, 32'h00000001});
      if (i == 5) q.push_back('{1'b0, 32'hCAFE0200});
      if (i == 4) bi.dwb_stb_i = 1'b0;
      if (i == 6) bi.iwb_stb_i = 1'b0;
      #1;
      nvec++;
      if (bi.arb_gnt_o !== eg[i]) begin
        nerr++; $display("FAIL wr_gnt[%0d] gnt=%b, required %b", i, bi.arb_gnt_o, eg[i]);
      end
      if (i >= 1 && i <= 3) begin
        nvec++;
        if (bi.wb_wre_o !== 1'b1 || bi.wb_dat_o !== 32'h7A55ED00 || bi.wb_adr_o !== 16'h8888 ||
            bi.wb_sel_o !== 4'hF) begin
          nerr++;
          $display("FAIL wr_bus[%0d] wre=%b dat=%h adr=%h sel=%h, required 1 7a55ed00 8888 f",
                   i, bi.wb_wre_o, bi.wb_dat_o, bi.wb_adr_o, bi.wb_sel_o);
        end
      end
      if (i == 4) begin
        nvec++;
        if (bi.wb_wre_o !== 1'b0 || bi.wb_dat_o !== 32'h0 || bi.wb_adr_o !== 16'h0200 ||
            bi.wb_sel_o !== 4'hF) begin
          nerr++;
          $display("FAIL wr_ibus wre=%b dat=%h adr=%h sel=%h, required 0 0 0200 f",
                   bi.wb_wre_o, bi.wb_dat_o, bi.wb_adr_o, bi.wb_sel_o);
        end
      end
      nvec++;
      if (q.size() > 0) begin
        e = q.pop_front();
        if ({bi.dwb_ack_o, bi.iwb_ack_o} !== (e.m ? 2'b10 : 2'b01) ||
            (e.m ? bi.dwb_dat_o : bi.iwb_dat_o) !== e.d) begin
          nerr++;
          $display("FAIL wr_ack[%0d] acks=%b%b idat=%h ddat=%h, required master %0d dat %h",
                   i, bi.dwb_ack_o, bi.iwb_ack_o, bi.iwb_dat_o, bi.dwb_dat_o, e.m, e.d);
        end
      end else if (bi.iwb_ack_o !== 1'b0 || bi.dwb_ack_o !== 1'b0) begin
        nerr++;
        $display("FAIL wr_noack[%0d] acks=%b%b, required 00", i, bi.dwb_ack_o, bi.iwb_ack_o);
      end
    end
    bi.dwb_we_i = 1'b0;
  endtask

  task automatic test_withdraw();
    logic [1:0] eg [7];
    eg = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    do_reset();
    bi.dwb_adr_i = 16'h0010; bi.iwb_adr_i = 16'h0020; bi.dwb_we_i = 1'b0;
    bi.dwb_stb_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      bi.wb_ack_i = (i == 1 || i == 4);
      bi.wb_dat_i = 32'h0BAD0BAD;
      if (i == 2) begin bi.dwb_stb_i = 1'b0; bi.iwb_stb_i = 1'b1; end
      if (i == 4) bi.iwb_stb_i = 1'b0;
      if (i == 5) begin bi.iwb_stb_i = 1'b1; bi.dwb_stb_i = 1'b1; end
      #1;
      nvec++;
      if (bi.arb_gnt_o !== eg[i]) begin
        nerr++; $display("FAIL wd_gnt[%0d] gnt=%b, required %b", i, bi.arb_gnt_o, eg[i]);
      end
      if (i == 4) begin
        nvec++;
        if (bi.wb_stb_o !== 1'b0 || bi.iwb_ack_o !== 1'b0 || bi.dwb_ack_o !== 1'b0) begin
          nerr++;
          $display("FAIL withdraw stb=%b acks=%b%b, required 0 00",
                   bi.wb_stb_o, bi.dwb_ack_o, bi.iwb_ack_o);
        end
      end
    end
    @(negedge clk);
    bi.iwb_stb_i = 1'b0; bi.dwb_stb_i = 1'b0; bi.wb_ack_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    exp_t e;
    do_reset();
    bi.iwb_adr_i = 16'h0300; bi.iwb_stb_i = 1'b1; bi.wb_dat_i = 32'hDEADBEEF;
    bz.iwb_adr_i = 16'h0300; bz.iwb_stb_i = 1'b1; bz.wb_dat_i = 32'hDEADBEEF;
    q.push_back('{1'b0, 32'h00000000});
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 5) bi.iwb_stb_i = 1'b0;
      #1;
      nvec++;
      if (bi.arb_gnt_o !== (i == 5 ? 2'b00 : 2'b01) || bi.arb_err_o !== (i == 4) ||
          bi.iwb_ack_o !== (i == 4)) begin
        nerr++;
        $display("FAIL wdog[%0d] gnt=%b err=%b ack=%b, required %b %b %b", i, bi.arb_gnt_o,
                 bi.arb_err_o, bi.iwb_ack_o, (i == 5 ? 2'b00 : 2'b01), (i == 4), (i == 4));
      end
      if (i == 4) begin
        e = q.pop_front();
        nvec++;
        if (bi.iwb_dat_o !== e.d) begin
          nerr++; $display("FAIL wdog_dat dat=%h, required %h", bi.iwb_dat_o, e.d);
        end
      end
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      nvec++;
      if (bz.arb_gnt_o !== 2'b01 || bz.arb_err_o !== 1'b0 || bz.iwb_ack_o !== 1'b0) begin
        nerr++;
        $display("FAIL tout0_hold[%0d] gnt=%b err=%b ack=%b, required 01 0 0",
                 i, bz.arb_gnt_o, bz.arb_err_o, bz.iwb_ack_o);
      end
    end
    bz.iwb_stb_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    nvec = 0; nerr = 0; rst = 1'b1;
    bi.iwb_adr_i = '0; bi.iwb_stb_i = 1'b0; bi.dwb_adr_i = '0; bi.dwb_dat_i = '0;
    bi.dwb_sel_i = '0; bi.dwb_we_i = 1'b0; bi.dwb_stb_i = 1'b0; bi.wb_dat_i = '0; bi.wb_ack_i = 1'b0;
    bz.iwb_adr_i = '0; bz.iwb_stb_i = 1'b0; bz.dwb_adr_i = '0; bz.dwb_dat_i = '0;
    bz.dwb_sel_i = '0; bz.dwb_we_i = 1'b0; bz.dwb_stb_i = 1'b0; bz.wb_dat_i = '0; bz.wb_ack_i = 1'b0;
    test_reset();
    test_iwb_read();
    test_tie();
    test_back_to_back();
    test_dwb_write();
    test_withdraw();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
